// File: rtl/inst_fetch_if.sv
// Purpose: bundles the fetch front end's memory-side and decode-side signals.
//   master : the fetch unit (drives pc and the out_* head, reads inst/redirect/out_ready)
//   slave  : instruction memory, branch unit and decode as seen from the fetch unit
// Ports (all 32 bits unless noted):
//   pc, inst, redirect(1), redirect_pc, out_valid(1), out_ready(1), out_inst, out_pc,
//   pc_oob(1, present only when INST_FETCH_WRAP_EN is not defined)
interface inst_fetch_if;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef INST_FETCH_WRAP_EN
  modport master (output pc, out_valid, out_inst, out_pc,
                  input  inst, redirect, redirect_pc, out_ready);
  modport slave  (input  pc, out_valid, out_inst, out_pc,
                  output inst, redirect, redirect_pc, out_ready);
`else
  logic        pc_oob;
  modport master (output pc, out_valid, out_inst, out_pc, pc_oob,
                  input  inst, redirect, redirect_pc, out_ready);
  modport slave  (input  pc, out_valid, out_inst, out_pc, pc_oob,
                  output inst, redirect, redirect_pc, out_ready);
`endif
endinterface

// File: rtl/inst_fetch.sv
// Purpose: instruction fetch front end. Issues word-index PCs to a memory with
//   one-cycle registered read, queues returned {inst, pc} pairs and hands them to
//   decode over valid/ready. A redirect flushes queued and in-flight fetches.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : inst_fetch_if.master (pc, inst, redirect, redirect_pc, out_valid,
//          out_ready, out_inst, out_pc, pc_oob)
// Configuration macro: INST_FETCH_WRAP_EN
//   defined   : pc and redirect targets wrap modulo MEM_DEPTH, no pc_oob
//   undefined : fetch stops when pc >= MEM_DEPTH and pc_oob is raised
module inst_fetch #(
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned MEM_DEPTH = 128,
  parameter int unsigned RESET_PC  = 0
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_pc;
  logic          r_req_q;
  logic [31:0]   r_req_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q_inst [QDEPTH];
  logic [31:0]   r_q_pc   [QDEPTH];

  logic          w_in_range;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_credit;
  logic [31:0]   w_pc_inc;
  logic [31:0]   w_redirect_pc;

  // Queued entries plus the outstanding request must leave room for the return.
  assign w_credit = {1'b0, r_count} + (CW+1)'(r_req_q);

`ifdef INST_FETCH_WRAP_EN
  assign w_in_range    = 1'b1;
  assign w_pc_inc      = (r_pc >= 32'(MEM_DEPTH - 1)) ? 32'd0 : r_pc + 32'd1;
  assign w_redirect_pc = bus.redirect_pc % 32'(MEM_DEPTH);
`else
  assign w_in_range    = (r_pc < 32'(MEM_DEPTH));
  assign w_pc_inc      = r_pc + 32'd1;
  assign w_redirect_pc = bus.redirect_pc;
  assign bus.pc_oob    = ~w_in_range;
`endif

  assign w_issue = (w_credit < (CW+1)'(QDEPTH)) && !bus.redirect && w_in_range;
  assign w_push  = r_req_q && !bus.redirect;
  assign w_pop   = (r_count != '0) && bus.out_ready;

  // PC, request tracking and queue; redirect overrides issue, push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= 32'(RESET_PC);
      r_req_q  <= 1'b0;
      r_req_pc <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else if (bus.redirect) begin
      r_pc     <= w_redirect_pc;
      r_req_q  <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_req_q <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
        r_pc     <= w_pc_inc;
      end
      if (w_push) begin
        r_q_inst[r_wr_ptr] <= bus.inst;
        r_q_pc[r_wr_ptr]   <= r_req_pc;
        r_wr_ptr           <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.pc        = r_pc;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_inst  = r_q_inst[r_rd_ptr];
  assign bus.out_pc    = r_q_pc[r_rd_ptr];

endmodule
